// File: rtl/core_types_pkg.sv
// Shared core types for the data-memory path: widths, request/writeback structs, LSU enums.
// Pure declarations; no timing or flow-control behaviour of its own.
package core_types_pkg;

    localparam int N_BITS       = 32;
    localparam int RF_IDX_WIDTH = 5;
    localparam int DMEM_STRB_W  = N_BITS / 8;

    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10
    } dmem_len_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_e;

    typedef struct packed {
        logic       vld;
        logic       mtype;
        logic [1:0] len;
    } dmem_req_ctrl_t;

    typedef struct packed {
        logic [RF_IDX_WIDTH-1:0] rd;
        logic                    vld;
    } rf_ctrl_t;

    localparam logic MTYPE_LOAD  = 1'b0;
    localparam logic MTYPE_STORE = 1'b1;

    // Reserved len (2'b11) is always treated as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] len, input logic [1:0] off);
        logic mis;
        case (len)
            LEN_B:   mis = 1'b0;
            LEN_H:   mis = off[0];
            LEN_W:   mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replication plus strobes, load extract plus extension.
// Zero latency, no flow control; the caller decides when the results are sampled.
module lsu_lane_align
    import core_types_pkg::*;
(
    input  logic [1:0]             st_len,
    input  logic [1:0]             st_off,
    input  logic [N_BITS-1:0]      st_data,
    output logic [N_BITS-1:0]      st_wdata,
    output logic [DMEM_STRB_W-1:0] st_wstrb,
    input  logic [1:0]             ld_len,
    input  logic [1:0]             ld_off,
    input  logic                   ld_unsigned,
    input  logic [N_BITS-1:0]      ld_data,
    output logic [N_BITS-1:0]      ld_result
);

    localparam logic [DMEM_STRB_W-1:0] STRB_B = DMEM_STRB_W'(1);
    localparam logic [DMEM_STRB_W-1:0] STRB_H = DMEM_STRB_W'(3);

    logic [N_BITS-1:0] ld_lane;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = '1;
        case (st_len)
            LEN_B: begin
                st_wdata = {(N_BITS/8){st_data[7:0]}};
                st_wstrb = STRB_B << st_off;
            end
            LEN_H: begin
                st_wdata = {(N_BITS/16){st_data[15:0]}};
                st_wstrb = STRB_H << st_off;
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = '1;
            end
        endcase
    end

    always_comb begin
        ld_lane   = ld_data >> {ld_off, 3'b000};
        ld_result = ld_lane;
        case (ld_len)
            LEN_B: ld_result = ld_unsigned ? {{(N_BITS-8){1'b0}}, ld_lane[7:0]}
                                           : {{(N_BITS-8){ld_lane[7]}}, ld_lane[7:0]};
            LEN_H: ld_result = ld_unsigned ? {{(N_BITS-16){1'b0}}, ld_lane[15:0]}
                                           : {{(N_BITS-16){ld_lane[15]}}, ld_lane[15:0]};
            default: ld_result = ld_lane;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// One-op-at-a-time load/store sequencer: request at T+1, load writeback >= 3 cycles after accept;
// dmem_req_* held stable under !dmem_req_rdy. LSU_MISALIGN_TRAP_EN selects reject vs force-align.
module lsu_ctrl
    import core_types_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_vld,
    output logic                     ex_rdy,
    input  dmem_req_ctrl_t           ex_ctrl,
    input  logic                     ex_unsigned,
    input  logic [N_BITS-1:0]        ex_addr,
    input  logic [N_BITS-1:0]        ex_wdata,
    input  logic [RF_IDX_WIDTH-1:0]  ex_rd,
    output logic                     dmem_req_vld,
    input  logic                     dmem_req_rdy,
    output dmem_req_ctrl_t           dmem_req_ctrl,
    output logic [N_BITS-1:0]        dmem_req_addr,
    output logic [N_BITS-1:0]        dmem_req_wdata,
    output logic [DMEM_STRB_W-1:0]   dmem_req_wstrb,
    input  logic                     dmem_rsp_vld,
    input  logic [N_BITS-1:0]        dmem_rsp_data,
    output rf_ctrl_t                 wb_ctrl,
    output logic [N_BITS-1:0]        wb_data,
    output logic                     misalign
);

    lsu_state_e                state_q, state_d;
    logic                      dmem_req_vld_q, dmem_req_vld_d;
    dmem_req_ctrl_t            dmem_req_ctrl_q, dmem_req_ctrl_d;
    logic [N_BITS-1:0]         dmem_req_addr_q, dmem_req_addr_d;
    logic [N_BITS-1:0]         dmem_req_wdata_q, dmem_req_wdata_d;
    logic [DMEM_STRB_W-1:0]    dmem_req_wstrb_q, dmem_req_wstrb_d;
    rf_ctrl_t                  wb_ctrl_q, wb_ctrl_d;
    logic [N_BITS-1:0]         wb_data_q, wb_data_d;
    logic                      misalign_q, misalign_d;

    logic                      cap_load_q, cap_load_d;
    logic                      cap_unsigned_q, cap_unsigned_d;
    logic [RF_IDX_WIDTH-1:0]   cap_rd_q, cap_rd_d;
    logic [1:0]                cap_len_q, cap_len_d;
    logic [1:0]                cap_off_q, cap_off_d;

    logic                      ex_mis;
    logic [1:0]                eff_len;
    logic [1:0]                eff_off;
    logic [N_BITS-1:0]         st_wdata;
    logic [DMEM_STRB_W-1:0]    st_wstrb;
    logic [N_BITS-1:0]         ld_result;

    logic unused_ex_ctrl_vld;
    assign unused_ex_ctrl_vld = ex_ctrl.vld;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        ex_mis  = lsu_misaligned(ex_ctrl.len, ex_addr[1:0]);
        eff_len = ex_ctrl.len;
        eff_off = ex_addr[1:0];
    end
`else
    // Without the trap, offending low bits are dropped and reserved len becomes a word.
    always_comb begin
        ex_mis  = 1'b0;
        eff_len = (ex_ctrl.len == 2'b11) ? LEN_W : ex_ctrl.len;
        case (eff_len)
            LEN_B:   eff_off = ex_addr[1:0];
            LEN_H:   eff_off = {ex_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end
`endif

    lsu_lane_align u_lane_align (
        .st_len      (eff_len),
        .st_off      (eff_off),
        .st_data     (ex_wdata),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_len      (cap_len_q),
        .ld_off      (cap_off_q),
        .ld_unsigned (cap_unsigned_q),
        .ld_data     (dmem_rsp_data),
        .ld_result   (ld_result)
    );

    always_comb begin
        state_d          = state_q;
        dmem_req_vld_d   = dmem_req_vld_q;
        dmem_req_ctrl_d  = dmem_req_ctrl_q;
        dmem_req_addr_d  = dmem_req_addr_q;
        dmem_req_wdata_d = dmem_req_wdata_q;
        dmem_req_wstrb_d = dmem_req_wstrb_q;
        wb_ctrl_d        = '0;
        wb_data_d        = wb_data_q;
        misalign_d       = 1'b0;
        cap_load_d       = cap_load_q;
        cap_unsigned_d   = cap_unsigned_q;
        cap_rd_d         = cap_rd_q;
        cap_len_d        = cap_len_q;
        cap_off_d        = cap_off_q;

        case (state_q)
            IDLE: begin
                if (ex_vld) begin
                    if (ex_mis) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d               = REQ;
                        dmem_req_vld_d        = 1'b1;
                        dmem_req_ctrl_d.vld   = 1'b1;
                        dmem_req_ctrl_d.mtype = ex_ctrl.mtype;
                        dmem_req_ctrl_d.len   = eff_len;
                        dmem_req_addr_d       = {ex_addr[N_BITS-1:2], 2'b00};
                        dmem_req_wdata_d      = (ex_ctrl.mtype == MTYPE_STORE) ? st_wdata : '0;
                        dmem_req_wstrb_d      = (ex_ctrl.mtype == MTYPE_STORE) ? st_wstrb : '0;
                        cap_load_d            = (ex_ctrl.mtype == MTYPE_LOAD);
                        cap_unsigned_d        = ex_unsigned;
                        cap_rd_d              = ex_rd;
                        cap_len_d             = eff_len;
                        cap_off_d             = eff_off;
                    end
                end
            end
            REQ: begin
                if (dmem_req_rdy) begin
                    dmem_req_vld_d      = 1'b0;
                    dmem_req_ctrl_d.vld = 1'b0;
                    state_d             = cap_load_q ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (dmem_rsp_vld) begin
                    state_d       = IDLE;
                    wb_ctrl_d.rd  = cap_rd_q;
                    wb_ctrl_d.vld = (cap_rd_q != '0);
                    wb_data_d     = ld_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            dmem_req_vld_q   <= 1'b0;
            dmem_req_ctrl_q  <= '0;
            dmem_req_addr_q  <= '0;
            dmem_req_wdata_q <= '0;
            dmem_req_wstrb_q <= '0;
            wb_ctrl_q        <= '0;
            wb_data_q        <= '0;
            misalign_q       <= 1'b0;
            cap_load_q       <= 1'b0;
            cap_unsigned_q   <= 1'b0;
            cap_rd_q         <= '0;
            cap_len_q        <= 2'b00;
            cap_off_q        <= 2'b00;
        end else begin
            state_q          <= state_d;
            dmem_req_vld_q   <= dmem_req_vld_d;
            dmem_req_ctrl_q  <= dmem_req_ctrl_d;
            dmem_req_addr_q  <= dmem_req_addr_d;
            dmem_req_wdata_q <= dmem_req_wdata_d;
            dmem_req_wstrb_q <= dmem_req_wstrb_d;
            wb_ctrl_q        <= wb_ctrl_d;
            wb_data_q        <= wb_data_d;
            misalign_q       <= misalign_d;
            cap_load_q       <= cap_load_d;
            cap_unsigned_q   <= cap_unsigned_d;
            cap_rd_q         <= cap_rd_d;
            cap_len_q        <= cap_len_d;
            cap_off_q        <= cap_off_d;
        end
    end

    assign ex_rdy         = (state_q == IDLE);
    assign dmem_req_vld   = dmem_req_vld_q;
    assign dmem_req_ctrl  = dmem_req_ctrl_q;
    assign dmem_req_addr  = dmem_req_addr_q;
    assign dmem_req_wdata = dmem_req_wdata_q;
    assign dmem_req_wstrb = dmem_req_wstrb_q;
    assign wb_ctrl        = wb_ctrl_q;
    assign wb_data        = wb_data_q;
    assign misalign       = misalign_q;

endmodule
